// File: rtl/rom_streamer.sv
// Streams a burst of consecutive ROM words (synchronous-read ROM, one-cycle latency)
// through a 2-entry output buffer with valid/ready handshake.
module rom_streamer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LOG_DEPTH-1:0] start_addr,
  input  logic [LOG_DEPTH:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic [LOG_DEPTH-1:0] address,
  input  logic [WIDTH-1:0]     rom_data,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  logic                 busy_r;
  logic                 done_r;
  logic [LOG_DEPTH-1:0] address_r;
  logic [LOG_DEPTH:0]   remaining_r;
  logic                 inflight_r;
  logic [1:0]           count_r;
  logic                 valid_r;
  logic [WIDTH-1:0]     head_r;
  logic [WIDTH-1:0]     tail_r;

  logic                 pop_s;
  logic [2:0]           occ_s;
  logic                 issue_s;
  logic [1:0]           count_nx_s;
  logic [LOG_DEPTH-1:0] addr_inc_s;

  assign busy      = busy_r;
  assign done      = done_r;
  assign address   = address_r;
  assign out_data  = head_r;
  assign out_valid = valid_r;

  // Slot accounting: a word leaving this cycle frees its slot for a new issue.
  always_comb begin
    pop_s      = valid_r & out_ready;
    occ_s      = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    count_nx_s = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    if ((state_r == RUN) && (occ_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (address_r == LOG_DEPTH'(DEPTH - 1)) begin
      addr_inc_s = '0;
    end else begin
      addr_inc_s = address_r + LOG_DEPTH'(1);
    end
  end

  // Control FSM, read issue and the two-entry output buffer (head_r is the oldest word).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      address_r   <= '0;
      remaining_r <= '0;
      inflight_r  <= 1'b0;
      count_r     <= 2'd0;
      valid_r     <= 1'b0;
      head_r      <= '0;
      tail_r      <= '0;
    end else begin
      done_r <= 1'b0;

      // The word issued last cycle is on rom_data now and is pushed unconditionally.
      case ({inflight_r, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= rom_data;
          end else begin
            tail_r <= rom_data;
          end
        end
        2'b01: head_r <= tail_r;
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= rom_data;
          end else begin
            head_r <= tail_r;
            tail_r <= rom_data;
          end
        end
        default: begin
        end
      endcase
      count_r    <= count_nx_s;
      valid_r    <= (count_nx_s != 2'd0);
      inflight_r <= issue_s;

      case (state_r)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              address_r   <= start_addr;
              remaining_r <= length;
              state_r     <= RUN;
              busy_r      <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue_s) begin
            address_r   <= addr_inc_s;
            remaining_r <= remaining_r - (LOG_DEPTH + 1)'(1);
            if (remaining_r == (LOG_DEPTH + 1)'(1)) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Buffer becomes empty with nothing in flight: done lands in the following cycle.
          if (occ_s == 3'd0) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
